sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter_pkg.sv | 20 ++
 rtl/sram_port_arbiter_if.sv | 37 +++
 rtl/sram_port_arbiter_rr_prio_picker.sv | 32 +++
 rtl/sram_port_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and FSM encoding for the SRAM port arbiter.
// Requester indices: SPI loader, CPU, ADC capture.
package sram_port_arbiter_pkg;

    localparam int unsigned DEF_MEMORY_DATA_WIDTH = 8;
    localparam int unsigned DEF_MEMORY_ADDR_WIDTH = 9;
    localparam int unsigned DEF_N_REQ             = 3;
    localparam int unsigned DEF_LOCK_MAX          = 16;

    localparam int unsigned REQ_SPI = 0;
    localparam int unsigned REQ_CPU = 1;
    localparam int unsigned REQ_ADC = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN    = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side and SRAM-side bundle of the arbiter; the arbiter uses the
// slave modport, the requesters plus SRAM macro use the master modport.
interface sram_port_arbiter_if
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned MEMORY_DATA_WIDTH = DEF_MEMORY_DATA_WIDTH,
    parameter int unsigned MEMORY_ADDR_WIDTH = DEF_MEMORY_ADDR_WIDTH,
    parameter int unsigned N_REQ             = DEF_N_REQ
) ();

    logic                                   EN;
    logic [N_REQ-1:0]                       REQ;
    logic [N_REQ-1:0]                       LOCK;
    logic [N_REQ-1:0]                       WEN_I;
    logic [N_REQ*MEMORY_ADDR_WIDTH-1:0]     A_I;
    logic [N_REQ*MEMORY_DATA_WIDTH-1:0]     D_I;
    logic [N_REQ-1:0]                       GNT;
    logic [N_REQ-1:0]                       RVLD;
    logic [MEMORY_DATA_WIDTH-1:0]           RDATA;
    logic                                   CEN_O;
    logic                                   WEN_O;
    logic [MEMORY_ADDR_WIDTH-1:0]           A_O;
    logic [MEMORY_DATA_WIDTH-1:0]           D_O;
    logic [MEMORY_DATA_WIDTH-1:0]           Q_I;
    logic                                   BUSY;

    modport slave (
        input  EN, REQ, LOCK, WEN_I, A_I, D_I, Q_I,
        output GNT, RVLD, RDATA, CEN_O, WEN_O, A_O, D_O, BUSY
    );

    modport master (
        output EN, REQ, LOCK, WEN_I, A_I, D_I, Q_I,
        input  GNT, RVLD, RDATA, CEN_O, WEN_O, A_O, D_O, BUSY
    );

endinterface

// File: rtl/sram_port_arbiter_rr_prio_picker.sv
// Rotating-priority picker: first requester at or after 'start' (wrapping)
// that is both requesting and unmasked wins.
module rr_prio_picker #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [N-1:0] eligible;
    int unsigned  pos;

    always_comb begin
        eligible = req & mask;
        gnt      = '0;
        valid    = 1'b0;
        pos      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(start) + k;
            if (pos >= N) pos = pos - N;
            if (!valid && eligible[pos[IW-1:0]]) begin
                gnt[pos[IW-1:0]] = 1'b1;
                valid            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: combinational rotating grant, registered SRAM
// drive one cycle later, read data returned two cycles after the grant.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned MEMORY_DATA_WIDTH = DEF_MEMORY_DATA_WIDTH,
    parameter int unsigned MEMORY_ADDR_WIDTH = DEF_MEMORY_ADDR_WIDTH,
    parameter int unsigned N_REQ             = DEF_N_REQ,
    parameter int unsigned LOCK_MAX          = DEF_LOCK_MAX
) (
    input logic                CLK,
    input logic                RST,
    sram_port_arbiter_if.slave bus
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    arb_state_e                   state;
    logic [IW-1:0]                last_ptr, owner, start, gnt_idx;
    logic [CW-1:0]                lock_cnt, cnt_next;
    logic [N_REQ-1:0]             excl, mask, gnt, rvld;
    logic                         gnt_vld, hold_lock;
    logic [MEMORY_ADDR_WIDTH-1:0] a_sel, a_q;
    logic [MEMORY_DATA_WIDTH-1:0] d_sel, d_q, rdata_q;
    logic                         cen_q, wen_q;
    logic [1:0]                   rd_vld;
    logic [IW-1:0]                rd_idx [2];

    // A held lock narrows eligibility to the owner; otherwise only the
    // owner that just hit LOCK_MAX is sat out for one arbitration.
    always_comb begin
        start     = (last_ptr == IW'(N_REQ - 1)) ? '0 : last_ptr + 1'b1;
        hold_lock = (state == ST_LOCKED) && bus.REQ[owner] && bus.LOCK[owner];
        mask      = '0;
        if (bus.EN) mask = hold_lock ? (N_REQ'(1) << owner) : ~excl;
    end

    rr_prio_picker #(.N(N_REQ)) u_picker (
        .req   (bus.REQ),
        .start (start),
        .mask  (mask),
        .gnt   (gnt),
        .valid (gnt_vld)
    );

    always_comb begin
        gnt_idx = '0;
        a_sel   = '0;
        d_sel   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = IW'(i);
                a_sel   = bus.A_I[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
                d_sel   = bus.D_I[i*MEMORY_DATA_WIDTH +: MEMORY_DATA_WIDTH];
            end
        end
        cnt_next = (state == ST_LOCKED && gnt_idx == owner) ? lock_cnt + 1'b1 : CW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            lock_cnt  <= '0;
            owner     <= '0;
            excl      <= '0;
            last_ptr  <= IW'(N_REQ - 1);
            cen_q     <= 1'b1;
            wen_q     <= 1'b1;
            a_q       <= '0;
            d_q       <= '0;
            rd_vld    <= '0;
            rd_idx[0] <= '0;
            rd_idx[1] <= '0;
            rdata_q   <= '0;
        end else begin
            excl <= '0;
            if (!gnt_vld) begin
                state    <= ST_IDLE;
                lock_cnt <= '0;
                cen_q    <= 1'b1;
                wen_q    <= 1'b1;
            end else begin
                last_ptr <= gnt_idx;
                owner    <= gnt_idx;
                cen_q    <= 1'b0;
                wen_q    <= bus.WEN_I[gnt_idx];
                a_q      <= a_sel;
                d_q      <= d_sel;
                if (bus.LOCK[gnt_idx] && cnt_next != CW'(LOCK_MAX)) begin
                    state    <= ST_LOCKED;
                    lock_cnt <= cnt_next;
                end else begin
                    state    <= ST_OWN;
                    lock_cnt <= '0;
                    if (bus.LOCK[gnt_idx]) excl <= gnt;
                end
            end
            rd_vld    <= {rd_vld[0], gnt_vld & bus.WEN_I[gnt_idx]};
            rd_idx[0] <= gnt_idx;
            rd_idx[1] <= rd_idx[0];
            if (rd_vld[1]) rdata_q <= bus.Q_I;
        end
    end

    always_comb begin
        rvld = '0;
        if (rd_vld[1]) rvld[rd_idx[1]] = 1'b1;
    end

    assign bus.GNT   = gnt;
    assign bus.RVLD  = rvld;
    assign bus.RDATA = rd_vld[1] ? bus.Q_I : rdata_q;
    assign bus.CEN_O = cen_q;
    assign bus.WEN_O = wen_q;
    assign bus.A_O   = a_q;
    assign bus.D_O   = d_q;
    assign bus.BUSY  = ~cen_q | (|rd_vld);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM and a
// read-return scoreboard keyed on the expected RVLD cycle.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    typedef struct {
        int unsigned due;
        int unsigned idx;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    logic [7:0]  shadow [512];
    logic [7:0]  mem [512];
    bit          mem_init = 1'b0;
    logic [7:0]  q = '0;

    sram_port_arbiter_if #(.MEMORY_DATA_WIDTH(8), .MEMORY_ADDR_WIDTH(9), .N_REQ(3)) bus ();

    sram_port_arbiter #(
        .MEMORY_DATA_WIDTH(8),
        .MEMORY_ADDR_WIDTH(9),
        .N_REQ(3),
        .LOCK_MAX(16)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pat(input logic [8:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Synchronous SRAM: read data appears the cycle after the access.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= pat(9'(i));
            mem_init <= 1'b1;
        end else if (!bus.CEN_O) begin
            if (!bus.WEN_O) mem[bus.A_O] <= bus.D_O;
            else            q <= mem[bus.A_O];
        end
    end
    assign bus.Q_I = q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] exp_rvld;
        exp_rvld = '0;
        if (sb.size() > 0 && sb[0].due == cyc) exp_rvld = 3'(1 << sb[0].idx);
        chk("rvld", 32'(bus.RVLD), 32'(exp_rvld));
        if (exp_rvld != '0) begin
            chk("rdata", 32'(bus.RDATA), 32'(sb[0].data));
            void'(sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic wen, input logic [8:0] a, input logic [7:0] d);
        bus.WEN_I[i]       = wen;
        bus.A_I[i*9 +: 9]  = a;
        bus.D_I[i*8 +: 8]  = d;
    endtask

    task automatic grant_step(input string tag, input logic [2:0] exp_gnt);
        logic [8:0] a;
        exp_t       e;
        @(negedge clk);
        chk(tag, 32'(bus.GNT), 32'(exp_gnt));
        for (int i = 0; i < 3; i++) begin
            if (exp_gnt[i]) begin
                a = bus.A_I[i*9 +: 9];
                if (bus.WEN_I[i]) begin
                    e.due  = cyc + 2;
                    e.idx  = i;
                    e.data = shadow[a];
                    sb.push_back(e);
                end else begin
                    shadow[a] = bus.D_I[i*8 +: 8];
                end
            end
        end
    endtask

    task automatic idle(input int n);
        bus.REQ  = '0;
        bus.LOCK = '0;
        repeat (n) begin
            grant_step("idle_gnt", 3'b000);
            tick();
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cen"},   32'(bus.CEN_O), 32'(1));
        chk({tag, "_wen"},   32'(bus.WEN_O), 32'(1));
        chk({tag, "_addr"},  32'(bus.A_O),   32'(0));
        chk({tag, "_dout"},  32'(bus.D_O),   32'(0));
        chk({tag, "_rdata"}, 32'(bus.RDATA), 32'(0));
        chk({tag, "_rvld"},  32'(bus.RVLD),  32'(0));
        chk({tag, "_busy"},  32'(bus.BUSY),  32'(0));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) shadow[i] = pat(9'(i));
        bus.EN   = 1'b0;
        bus.REQ  = '0;
        bus.LOCK = '0;
        set_port(REQ_SPI, 1'b1, 9'h010, 8'h11);
        set_port(REQ_CPU, 1'b1, 9'h021, 8'h22);
        set_port(REQ_ADC, 1'b1, 9'h032, 8'h33);

        // Power-on reset values
        @(negedge clk);
        @(negedge clk);
        chk_reset_outs("por");
        chk("por_gnt", 32'(bus.GNT), 32'(0));
        tick();
        rst = 1'b0;

        // S1: all three read continuously, rotation from requester 0
        bus.EN  = 1'b1;
        bus.REQ = 3'b111;
        grant_step("s1_g1", 3'b001); tick();
        grant_step("s1_g2", 3'b010);
        chk("s1_cen",  32'(bus.CEN_O), 32'(0));
        chk("s1_wen",  32'(bus.WEN_O), 32'(1));
        chk("s1_addr", 32'(bus.A_O),   32'(9'h010));
        chk("s1_busy", 32'(bus.BUSY),  32'(1));
        tick();
        grant_step("s1_g3", 3'b100); tick();
        grant_step("s1_g4", 3'b001); tick();
        idle(3);
        @(negedge clk);
        chk("s1_cen_idle", 32'(bus.CEN_O), 32'(1));
        tick();

        // S2: CPU writes A5 to 1FF, then reads it back next cycle
        bus.REQ = 3'b010;
        set_port(REQ_CPU, 1'b0, 9'h1FF, 8'hA5);
        grant_step("s2_wr", 3'b010); tick();
        set_port(REQ_CPU, 1'b1, 9'h1FF, 8'h00);
        grant_step("s2_rd", 3'b010);
        chk("s2_wr_wen",  32'(bus.WEN_O), 32'(0));
        chk("s2_wr_addr", 32'(bus.A_O),   32'(9'h1FF));
        chk("s2_wr_data", 32'(bus.D_O),   32'(8'hA5));
        tick();
        idle(3);
        @(negedge clk);
        chk("s2_rdata_hold", 32'(bus.RDATA), 32'(8'hA5));
        tick();

        // S3: requester 0 locked for LOCK_MAX grants, then forced out
        bus.REQ  = 3'b001;
        bus.LOCK = 3'b001;
        grant_step("s3_lock_1", 3'b001); tick();
        bus.REQ = 3'b111;
        for (int k = 2; k <= 16; k++) begin
            grant_step("s3_lock_n", 3'b001);
            tick();
        end
        grant_step("s3_g17", 3'b010); tick();
        grant_step("s3_g18", 3'b100); tick();
        idle(3);

        // Lock released by the owner dropping LOCK
        bus.REQ  = 3'b111;
        bus.LOCK = 3'b001;
        grant_step("s3b_lock", 3'b001); tick();
        bus.LOCK = 3'b000;
        grant_step("s3b_unlock", 3'b010); tick();
        idle(3);

        // S4: EN dropped the cycle after a read grant
        bus.REQ = 3'b100;
        grant_step("s4_g", 3'b100); tick();
        bus.EN  = 1'b0;
        bus.REQ = 3'b111;
        grant_step("s4_en0_a", 3'b000);
        chk("s4_cen_a",  32'(bus.CEN_O), 32'(0));
        chk("s4_busy_a", 32'(bus.BUSY),  32'(1));
        tick();
        grant_step("s4_en0_b", 3'b000);
        chk("s4_cen_b", 32'(bus.CEN_O), 32'(1));
        tick();
        idle(2);

        // EN low releases a held lock
        bus.EN   = 1'b1;
        bus.REQ  = 3'b001;
        bus.LOCK = 3'b001;
        grant_step("s4b_lock", 3'b001); tick();
        bus.EN = 1'b0;
        grant_step("s4b_en0", 3'b000); tick();
        bus.EN  = 1'b1;
        bus.REQ = 3'b011;
        grant_step("s4b_released", 3'b010); tick();
        idle(3);

        // S5: reset one cycle after a read grant discards the read
        bus.REQ = 3'b001;
        grant_step("s5_g", 3'b001); tick();
        rst     = 1'b1;
        bus.REQ = '0;
        sb.delete();
        @(negedge clk);
        chk_reset_outs("s5_rst");
        tick();
        @(negedge clk);
        chk("s5_rst_rvld", 32'(bus.RVLD), 32'(0));
        tick();
        rst     = 1'b0;
        bus.REQ = 3'b111;
        grant_step("s5_first", 3'b001); tick();
        idle(3);

        // S6: a request pulse while EN is low does nothing
        bus.EN  = 1'b0;
        bus.REQ = 3'b100;
        grant_step("s6_gnt", 3'b000);
        chk("s6_busy_a", 32'(bus.BUSY), 32'(0));
        tick();
        bus.REQ = '0;
        grant_step("s6_gnt_b", 3'b000);
        chk("s6_cen",    32'(bus.CEN_O), 32'(1));
        chk("s6_busy_b", 32'(bus.BUSY),  32'(0));
        tick();

        idle(3);
        chk("sb_drain", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
